// File: rtl/alu_pkg.sv
// Shared types and constants for the 8-bit ALU: opcode enum, shift kinds,
// and flag bit positions inside OutFlag.
package alu_pkg;

  // Operation select carried on FunSel.
  typedef enum logic [3:0] {
    OP_PASSA = 4'b0000,
    OP_PASSB = 4'b0001,
    OP_NOTA  = 4'b0010,
    OP_NOTB  = 4'b0011,
    OP_ADD   = 4'b0100,
    OP_ADDC  = 4'b0101,
    OP_SUB   = 4'b0110,
    OP_AND   = 4'b0111,
    OP_OR    = 4'b1000,
    OP_XOR   = 4'b1001,
    OP_LSL   = 4'b1010,
    OP_LSR   = 4'b1011,
    OP_ASL   = 4'b1100,
    OP_ASR   = 4'b1101,
    OP_CSL   = 4'b1110,
    OP_CSR   = 4'b1111
  } alu_op_e;

  // Shift kinds share the low three opcode bits so the top can pass
  // FunSel[2:0] straight through for shift operations.
  typedef enum logic [2:0] {
    SH_LSL = 3'b010,
    SH_LSR = 3'b011,
    SH_ASL = 3'b100,
    SH_ASR = 3'b101,
    SH_CSL = 3'b110,
    SH_CSR = 3'b111
  } shift_kind_e;

  // Bit positions inside the flag register.
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

endpackage

// File: rtl/alu_shifter.sv
// Combinational single-bit shifter/rotator for the ALU. Returns the shifted
// value and the bit that falls off the end (used as the new carry).
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  shift_kind_e      kind_i,
  output logic [WIDTH-1:0] data_o,
  output logic             out_bit_o
);

  // Select the shifted data and the bit shifted out for each shift kind.
  always_comb begin
    data_o    = a_i;
    out_bit_o = 1'b0;
    case (kind_i)
      SH_LSL, SH_ASL: begin
        data_o    = {a_i[WIDTH-2:0], 1'b0};
        out_bit_o = a_i[WIDTH-1];
      end
      SH_LSR: begin
        data_o    = {1'b0, a_i[WIDTH-1:1]};
        out_bit_o = a_i[0];
      end
      SH_ASR: begin
        data_o    = {a_i[WIDTH-1], a_i[WIDTH-1:1]};
        out_bit_o = a_i[0];
      end
      SH_CSL: begin
        data_o    = {a_i[WIDTH-2:0], a_i[WIDTH-1]};
        out_bit_o = a_i[WIDTH-1];
      end
      SH_CSR: begin
        data_o    = {a_i[0], a_i[WIDTH-1:1]};
        out_bit_o = a_i[0];
      end
      default: begin
        data_o    = a_i;
        out_bit_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu.sv
// Combinational arithmetic/logic unit with a registered Z/C/N/O flag
// register. The result is purely combinational; only the flags are clocked.
// Optional build macro ALU_FLAG_WRITE_EN adds a WF input that gates flag
// updates (reset still clears the flags regardless of WF).
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
`ifdef ALU_FLAG_WRITE_EN
  input  logic             WF,
`endif
  input  logic [3:0]       FunSel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] OutALU,
  output logic [3:0]       OutFlag
);

  localparam int MSB = WIDTH - 1;

  alu_op_e          op;
  logic [3:0]       flag_q;
  logic [3:0]       flag_d;
  logic             flag_we;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] shift_data;
  logic             shift_bit;
  logic             set_z;
  logic             set_n;

  assign op = alu_op_e'(FunSel);

`ifdef ALU_FLAG_WRITE_EN
  assign flag_we = WF;
`else
  assign flag_we = 1'b1;
`endif

  alu_shifter #(
    .WIDTH(WIDTH)
  ) u_shifter (
    .a_i      (A),
    .kind_i   (shift_kind_e'(FunSel[2:0])),
    .data_o   (shift_data),
    .out_bit_o(shift_bit)
  );

  // One shared adder: subtraction is A + ~B + 1, add-with-carry uses the
  // carry already stored in the flag register (not the one being computed).
  always_comb begin
    add_b   = B;
    add_cin = 1'b0;
    if (op == OP_SUB) begin
      add_b   = ~B;
      add_cin = 1'b1;
    end else if (op == OP_ADDC) begin
      add_cin = flag_q[FLAG_C];
    end
    sum_ext = {1'b0, A} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
  end

  // Result mux and next-flag computation; untouched flags hold their value.
  always_comb begin
    result = '0;
    flag_d = flag_q;
    set_z  = 1'b1;
    set_n  = 1'b1;
    case (op)
      OP_PASSA: result = A;
      OP_PASSB: result = B;
      OP_NOTA:  result = ~A;
      OP_NOTB:  result = ~B;
      OP_ADD, OP_ADDC: begin
        result         = sum_ext[WIDTH-1:0];
        flag_d[FLAG_C] = sum_ext[WIDTH];
        flag_d[FLAG_O] = (A[MSB] == B[MSB]) && (sum_ext[MSB] != A[MSB]);
      end
      OP_SUB: begin
        result         = sum_ext[WIDTH-1:0];
        flag_d[FLAG_C] = sum_ext[WIDTH];
        flag_d[FLAG_O] = (A[MSB] != B[MSB]) && (sum_ext[MSB] != A[MSB]);
      end
      OP_AND: result = A & B;
      OP_OR:  result = A | B;
      OP_XOR: result = A ^ B;
      OP_LSL, OP_LSR, OP_CSL, OP_CSR: begin
        result         = shift_data;
        flag_d[FLAG_C] = shift_bit;
      end
      OP_ASL: begin
        result         = shift_data;
        flag_d[FLAG_C] = shift_bit;
        flag_d[FLAG_O] = A[MSB] ^ A[MSB-1];
      end
      OP_ASR: begin
        // Arithmetic right shift keeps the sign, so N is left as it was.
        result         = shift_data;
        flag_d[FLAG_C] = shift_bit;
        set_n          = 1'b0;
      end
      default: begin
        // Illegal/unknown select: zero result, all flags held.
        result = '0;
        set_z  = 1'b0;
        set_n  = 1'b0;
      end
    endcase
    if (set_z) begin
      flag_d[FLAG_Z] = (result == '0);
    end
    if (set_n) begin
      flag_d[FLAG_N] = result[MSB];
    end
  end

  // Flag register: reset wins over any update.
  always_ff @(posedge CLK) begin
    if (RST) begin
      flag_q <= 4'b0000;
    end else if (flag_we) begin
      flag_q <= flag_d;
    end
  end

  assign OutALU  = result;
  assign OutFlag = flag_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases from the test plan plus
// randomized operations checked against an integer-arithmetic reference.
module tb_alu;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       WF  = 1'b1;
  logic [3:0] FunSel = 4'd0;
  logic [7:0] A = 8'd0;
  logic [7:0] B = 8'd0;
  logic [7:0] OutALU;
  logic [3:0] OutFlag;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [3:0] mflags   = 4'b0000;

  always #5 CLK = ~CLK;

  alu #(.WIDTH(8)) dut (
    .CLK    (CLK),
    .RST    (RST),
`ifdef ALU_FLAG_WRITE_EN
    .WF     (WF),
`endif
    .FunSel (FunSel),
    .A      (A),
    .B      (B),
    .OutALU (OutALU),
    .OutFlag(OutFlag)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic int to_signed(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic bit out_of_range(input int s);
    return (s > 127) || (s < -128);
  endfunction

  // Reference model: plain integer arithmetic on 0..255 values.
  // Flag vector order: {Z, C, N, O}.
  function automatic void model(input int op, input int a, input int b,
                                input logic [3:0] fin,
                                output int r, output logic [3:0] fout);
    logic z, c, n, o;
    int   sa, sb, full, cin;
    z = fin[3]; c = fin[2]; n = fin[1]; o = fin[0];
    sa = to_signed(a); sb = to_signed(b);
    cin = fin[2] ? 1 : 0;
    r = 0;
    case (op)
      0:  r = a;
      1:  r = b;
      2:  r = 255 - a;
      3:  r = 255 - b;
      4:  begin full = a + b; r = full % 256; c = (full > 255); o = out_of_range(sa + sb); end
      5:  begin full = a + b + cin; r = full % 256; c = (full > 255); o = out_of_range(sa + sb + cin); end
      6:  begin full = a - b; r = (full + 256) % 256; c = (a >= b); o = out_of_range(sa - sb); end
      7:  r = a & b;
      8:  r = a | b;
      9:  r = a ^ b;
      10: begin r = (a * 2) % 256; c = (a >= 128); end
      11: begin r = a / 2; c = (a % 2 == 1); end
      12: begin r = (a * 2) % 256; c = (a >= 128); o = out_of_range(sa * 2); end
      13: begin r = a / 2 + ((a >= 128) ? 128 : 0); c = (a % 2 == 1); end
      14: begin r = (a * 2) % 256 + a / 128; c = (a >= 128); end
      default: begin r = a / 2 + (a % 2) * 128; c = (a % 2 == 1); end
    endcase
    z = (r == 0);
    if (op != 13) n = (r >= 128);
    fout = {z, c, n, o};
  endfunction

  // Drive one operation, check the combinational result, clock it, check flags.
  task automatic do_op(input int op, input int a, input int b, input bit wf);
    int         r;
    logic [3:0] f;
    @(negedge CLK);
    FunSel = op[3:0];
    A      = a[7:0];
    B      = b[7:0];
    WF     = wf;
    RST    = 1'b0;
    #1;
    model(op, a, b, mflags, r, f);
    check("result", {24'd0, OutALU}, r);
    @(posedge CLK);
    #1;
`ifdef ALU_FLAG_WRITE_EN
    if (wf) mflags = f;
`else
    mflags = f;
`endif
    check("flags", {28'd0, OutFlag}, {28'd0, mflags});
    $display("op=%h a=%02h b=%02h wf=%0d -> out=%02h flags=%b", op[3:0], a[7:0], b[7:0], wf, OutALU, OutFlag);
  endtask

  // Assert reset for one edge while arbitrary inputs are applied.
  task automatic do_reset();
    @(negedge CLK);
    RST    = 1'b1;
    FunSel = 4'($urandom_range(0, 15));
    A      = 8'($urandom);
    B      = 8'($urandom);
    WF     = 1'b1;
    @(posedge CLK);
    #1;
    mflags = 4'b0000;
    check("reset_flags", {28'd0, OutFlag}, 32'h0);
    $display("reset -> flags=%b", OutFlag);
    RST = 1'b0;
  endtask

  initial begin
    // Reset and pass-through.
    do_reset();
    do_op(1, 8'h00, 8'h5A, 1'b1);
    check("tp_passb_out", {24'd0, OutALU}, 32'h5A);
    check("tp_passb_flags", {28'd0, OutFlag}, 32'h0);

    // Addition overflow and carry.
    do_op(4, 8'h7F, 8'h01, 1'b1);
    check("tp_add_ovf", {28'd0, OutFlag}, 32'h3);
    do_op(4, 8'hFF, 8'h01, 1'b1);
    check("tp_add_carry", {28'd0, OutFlag}, 32'hC);
    // Add with the stored carry (C=1 now).
    do_op(5, 8'h01, 8'h01, 1'b1);
    check("tp_addc_flags", {28'd0, OutFlag}, 32'h0);

    // Subtraction.
    do_op(6, 8'h05, 8'h05, 1'b1);
    check("tp_sub_eq", {28'd0, OutFlag}, 32'hC);
    do_op(6, 8'h80, 8'h01, 1'b1);
    check("tp_sub_ovf", {28'd0, OutFlag}, 32'h5);
    do_op(6, 8'h00, 8'h01, 1'b1);
    check("tp_sub_borrow", {28'd0, OutFlag}, 32'h2);

    // Shifts, each from cleared flags.
    do_reset(); do_op(14, 8'h81, 8'h00, 1'b1);
    check("tp_csl", {20'd0, OutALU, OutFlag}, 32'h034);
    do_reset(); do_op(15, 8'h01, 8'h00, 1'b1);
    check("tp_csr", {20'd0, OutALU, OutFlag}, 32'h806);
    do_reset(); do_op(13, 8'h80, 8'h00, 1'b1);
    check("tp_asr", {20'd0, OutALU, OutFlag}, 32'hC00);
    do_reset(); do_op(11, 8'h01, 8'h00, 1'b1);
    check("tp_lsr", {20'd0, OutALU, OutFlag}, 32'h00C);

    // Preserve rules: reach flags=0100, then a logic op keeps C.
    do_reset(); do_op(14, 8'h80, 8'h00, 1'b1);
    check("tp_set_c", {28'd0, OutFlag}, 32'h4);
`ifdef ALU_FLAG_WRITE_EN
    do_op(7, 8'hF0, 8'h0F, 1'b0);
    check("tp_wf_hold", {28'd0, OutFlag}, 32'h4);
`endif
    do_op(7, 8'hF0, 8'h0F, 1'b1);
    check("tp_and_keep_c", {28'd0, OutFlag}, 32'hC);

    // Randomized operations against the reference model.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0)
        do_reset();
      else begin
`ifdef ALU_FLAG_WRITE_EN
        do_op($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 3) != 0));
`else
        do_op($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255), 1'b1);
`endif
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Combinational 8-bit arithmetic/logic unit with a registered 4-bit flag register (Z, C, N, O).
- Sits between the register-file outputs (A, B) and the MuxA/MuxC/memory write paths of the ALU system.
- The result is combinational from A, B, FunSel and the stored C flag.
- Flags update on the rising CLK edge.

Parameters:
- WIDTH, 8, data width of A, B and OutALU. All flag rules below refer to the MSB, bit WIDTH-1.

Ports:
- CLK  input  1  system clock; flags update on the rising edge.
- RST  input  1  synchronous, active-high reset; clears the flag register.
- FunSel  input  4  operation select.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- OutALU  output  WIDTH  combinational result.
- OutFlag  output  4  registered flags: [3]=Z, [2]=C, [1]=N, [0]=O.

Behaviour:
- One clock. Reset is synchronous and active-high.
- On RST=1 at a rising CLK edge, OutFlag becomes 4'b0000. RST has priority over the flag update.
- OutALU is never reset. It always reflects the current inputs.
- FunSel encoding:
  - 0000 A
  - 0001 B
  - 0010 ~A
  - 0011 ~B
  - 0100 A+B
  - 0101 A+B+Cstored
  - 0110 A-B, computed as A+~B+1
  - 0111 A&B
  - 1000 A|B
  - 1001 A^B
  - 1010 LSL A (shift left, 0 in)
  - 1011 LSR A (shift right, 0 in)
  - 1100 ASL A (same data as LSL)
  - 1101 ASR A (MSB replicated)
  - 1110 CSL A (rotate left, bit7 to bit0)
  - 1111 CSR A (rotate right, bit0 to bit7)
- Arithmetic is modulo 2^WIDTH. Carry-out is bit WIDTH of the (WIDTH+1)-bit sum.
- For subtraction, C=1 means no borrow (A>=B unsigned).
- Flag update, on every rising edge when RST=0, from the combinational result of that cycle:
  - Z: (OutALU==0). Updated for all ops.
  - N: OutALU[MSB]. Updated for all ops except ASR, which preserves N.
  - C:
    - add/addc/sub: carry-out.
    - LSL/ASL/CSL: A[MSB].
    - LSR/ASR/CSR: A[0].
    - All other ops preserve C.
  - O:
    - add/addc: (A[MSB]==B[MSB]) && (OutALU[MSB]!=A[MSB]).
    - sub: (A[MSB]!=B[MSB]) && (OutALU[MSB]!=A[MSB]).
    - ASL: A[MSB]^A[MSB-1].
    - All other ops preserve O.
- FunSel=0101 uses the C value stored in OutFlag before the edge, never the value being computed.
- Unknown or X FunSel is not a legal state. The default branch drives OutALU=0 and leaves flags unchanged.

Optional Feature:
- Macro ALU_FLAG_WRITE_EN.
- When defined: adds input port WF (1 bit). Flags update only on edges where WF=1. With WF=0 all four flags hold. RST still clears them regardless of WF.
- When undefined: no WF port, and flags update on every non-reset edge as above.

Decomposition:
- Package alu_pkg holds:
  - the 4-bit opcode enum (OP_PASSA ... OP_CSR);
  - flag index constants FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_O=0.
- One natural sub-module, alu_shifter: purely combinational. It takes A and a 3-bit shift kind and returns the shifted value and the shifted-out bit.
- The adder, logic ops and the flag register remain in alu.

Test Plan:
- RST=1 for one edge, then RST=0 -> OutFlag=0000. With FunSel=0001, B=0x5A -> OutALU=0x5A; next edge OutFlag=0000.
- FunSel=0100, A=0x7F, B=0x01 -> OutALU=0x80; after edge OutFlag=0011 (N=1, O=1). Then A=0xFF, B=0x01 -> OutALU=0x00; after edge OutFlag=1100 (Z=1, C=1).
- With C=1 stored: FunSel=0101, A=0x01, B=0x01 -> OutALU=0x03; after edge C=0, OutFlag=0000.
- FunSel=0110:
  - A=0x05, B=0x05 -> 0x00, flags 1100.
  - A=0x80, B=0x01 -> 0x7F, flags 0101 (C=1, O=1).
  - A=0x00, B=0x01 -> 0xFF, flags 0010.
- Shifts, each starting from C=0:
  - CSL A=0x81 -> 0x03, C=1.
  - CSR A=0x01 -> 0x80, C=1, N=1.
  - ASR A=0x80 -> 0xC0, N unchanged.
  - LSR A=0x01 -> 0x00, Z=1, C=1.
- Preserve rules: after flags=0100, FunSel=0111, A=0xF0, B=0x0F -> OutALU=0x00, flags=1100 (C kept). Under ALU_FLAG_WRITE_EN, WF=0 -> flags remain 0100.
